cci_mpf_mem_responder: RTL and testbench

//  Responder end of the MPF request interface: accepts MPF C0 read and C1 write/interrupt requests
//  and returns CCI RX responses from a small internal line memory. Used as the FIU-side endpoint in
//  MPF unit benches and loopback builds. Request mdata is echoed unchanged; fixed, configurable latency.

---
 rtl/cci_mpf_mem_responder_pkg.sv | 67 ++++++
 rtl/cci_mpf_mem_responder_fifo.sv | 68 ++++++
 rtl/cci_mpf_mem_responder.sv | 136 +++++++++++++
 tb/tb_cci_mpf_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_mem_responder_pkg.sv
// CCI/MPF request and response types shared by the memory responder and its benches.
// Field names follow the CCI header layout so MPF code can be connected directly.
package cci_mpf_mem_responder_pkg;

    localparam int CCI_CLDATA_WIDTH          = 512;
    localparam int CCI_MDATA_WIDTH           = 16;
    localparam int CCI_CLADDR_WIDTH          = 42;
    localparam int CCI_ALMOST_FULL_THRESHOLD = 8;

    typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_cldata;
    typedef logic [CCI_MDATA_WIDTH-1:0]  t_cci_mdata;
    typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1,
        eRSP_INTR   = 4'h8
    } t_cci_rsp_type;

    typedef struct packed {
        t_cci_rsp_type resp_type;
        t_cci_mdata    mdata;
    } t_cci_RspMemHdr;

    typedef struct packed {
        logic addrIsVirtual;
    } t_cci_mpf_ReqMemHdrExt;

    typedef struct packed {
        t_cci_clAddr address;
        t_cci_mdata  mdata;
    } t_cci_ReqMemHdr;

    typedef struct packed {
        t_cci_mpf_ReqMemHdrExt ext;
        t_cci_ReqMemHdr        base;
    } t_cci_mpf_ReqMemHdr;

    typedef struct packed {
        t_cci_mpf_ReqMemHdr hdr;
        logic               rdValid;
    } t_if_cci_mpf_c0_Tx;

    typedef struct packed {
        t_cci_mpf_ReqMemHdr hdr;
        t_cci_cldata        data;
        logic               wrValid;
        logic               intrValid;
    } t_if_cci_mpf_c1_Tx;

    function automatic logic cci_mpf_c0TxIsValid(input t_if_cci_mpf_c0_Tx tx);
        return tx.rdValid;
    endfunction

    function automatic logic cci_mpf_c1TxIsValid(input t_if_cci_mpf_c1_Tx tx);
        return tx.wrValid | tx.intrValid;
    endfunction

    function automatic t_cci_RspMemHdr cci_genRspHdr(input t_cci_rsp_type rsp_type,
                                                      input t_cci_mdata mdata);
        t_cci_RspMemHdr hdr;
        hdr.resp_type = rsp_type;
        hdr.mdata     = mdata;
        return hdr;
    endfunction

endpackage

// File: rtl/cci_mpf_mem_responder_fifo.sv
// Request FIFO with registered almost-full and a sticky overflow flag.
// An enqueue at full is dropped; the head entry is visible combinationally on deq_data.
module cci_mpf_mem_responder_fifo
    import cci_mpf_mem_responder_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int DEPTH             = 16,
    parameter int ALMFULL_THRESHOLD = CCI_ALMOST_FULL_THRESHOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_en,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq_en,
    output logic [WIDTH-1:0] deq_data,
    output logic             not_empty,
    output logic             almfull,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             full;
    logic             do_enq;
    logic             do_deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign do_enq    = enq_en && !full;
    assign do_deq    = deq_en && not_empty;
    assign deq_data  = store[rd_ptr];

    always_comb begin
        next_count = count + CNT_W'(do_enq) - CNT_W'(do_deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            almfull  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_enq) wr_ptr <= ptr_inc(wr_ptr);
            if (do_deq) rd_ptr <= ptr_inc(rd_ptr);
            count    <= next_count;
            almfull  <= (next_count >= CNT_W'(DEPTH - ALMFULL_THRESHOLD));
            if (enq_en && full) overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_enq) store[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/cci_mpf_mem_responder.sv
// FIU-side endpoint for MPF benches: services C0 reads and C1 writes/interrupts from a
// small line memory and returns CCI responses a fixed LATENCY cycles after dequeue.
module cci_mpf_mem_responder
    import cci_mpf_mem_responder_pkg::*;
#(
    parameter int MEM_LINES      = 64,
    parameter int REQ_FIFO_DEPTH = 16,
    parameter int LATENCY        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  t_if_cci_mpf_c0_Tx c0_tx,
    input  t_if_cci_mpf_c1_Tx c1_tx,
    output logic              c0_tx_almfull,
    output logic              c1_tx_almfull,
    output logic              c0_rsp_valid,
    output t_cci_RspMemHdr    c0_rsp_hdr,
    output t_cci_cldata       c0_rsp_data,
    output logic              c1_rsp_valid,
    output t_cci_RspMemHdr    c1_rsp_hdr,
    output logic              err_overflow,
    output logic              err_vaddr
);

    localparam int IDX_W = $clog2(MEM_LINES);

    t_if_cci_mpf_c0_Tx c0_head;
    t_if_cci_mpf_c1_Tx c1_head;
    logic              c0_avail;
    logic              c1_avail;
    logic              c0_ovf;
    logic              c1_ovf;

    cci_mpf_mem_responder_fifo #(
        .WIDTH ($bits(t_if_cci_mpf_c0_Tx)),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_c0_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_en    (cci_mpf_c0TxIsValid(c0_tx)),
        .enq_data  (c0_tx),
        .deq_en    (1'b1),
        .deq_data  (c0_head),
        .not_empty (c0_avail),
        .almfull   (c0_tx_almfull),
        .overflow  (c0_ovf)
    );

    cci_mpf_mem_responder_fifo #(
        .WIDTH ($bits(t_if_cci_mpf_c1_Tx)),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_c1_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_en    (cci_mpf_c1TxIsValid(c1_tx)),
        .enq_data  (c1_tx),
        .deq_en    (1'b1),
        .deq_data  (c1_head),
        .not_empty (c1_avail),
        .almfull   (c1_tx_almfull),
        .overflow  (c1_ovf)
    );

    assign err_overflow = c0_ovf | c1_ovf;

    // Upper address bits alias by design; ext and the qualifier bits are consumed at enqueue.
    logic unused_head;
    assign unused_head = ^{c0_head.hdr.ext, c0_head.hdr.base.address[CCI_CLADDR_WIDTH-1:IDX_W],
                           c0_head.rdValid, c1_head.hdr.ext, c1_head.intrValid,
                           c1_head.hdr.base.address[CCI_CLADDR_WIDTH-1:IDX_W]};

    logic [IDX_W-1:0] c0_idx;
    logic [IDX_W-1:0] c1_idx;
    logic             c1_do_write;

    assign c0_idx      = c0_head.hdr.base.address[IDX_W-1:0];
    assign c1_idx      = c1_head.hdr.base.address[IDX_W-1:0];
    // wrValid wins over intrValid when both are set.
    assign c1_do_write = c1_avail && c1_head.wrValid;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_vaddr <= 1'b0;
        end else if ((c0_tx.rdValid && c0_tx.hdr.ext.addrIsVirtual) ||
                     (cci_mpf_c1TxIsValid(c1_tx) && c1_tx.hdr.ext.addrIsVirtual)) begin
            err_vaddr <= 1'b1;
        end
    end

    t_cci_cldata mem [MEM_LINES];

    // NOTE: the read below samples mem with the same non-blocking update, so a same-cycle
    // read of the written index returns the old line (read-before-write).
    always_ff @(posedge clk) begin
        if (c1_do_write) mem[c1_idx] <= c1_head.data;
    end

    logic           c0_v [LATENCY];
    t_cci_RspMemHdr c0_h [LATENCY];
    t_cci_cldata    c0_d [LATENCY];
    logic           c1_v [LATENCY];
    t_cci_RspMemHdr c1_h [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                c0_v[i] <= 1'b0;
                c0_h[i] <= '0;
                c0_d[i] <= '0;
                c1_v[i] <= 1'b0;
                c1_h[i] <= '0;
            end
        end else begin
            c0_v[0] <= c0_avail;
            c0_h[0] <= c0_avail ? cci_genRspHdr(eRSP_RDLINE, c0_head.hdr.base.mdata) : '0;
            c0_d[0] <= c0_avail ? mem[c0_idx] : '0;
            c1_v[0] <= c1_avail;
            c1_h[0] <= c1_avail ? cci_genRspHdr(c1_head.wrValid ? eRSP_WRLINE : eRSP_INTR,
                                                c1_head.hdr.base.mdata) : '0;
            for (int i = 1; i < LATENCY; i++) begin
                c0_v[i] <= c0_v[i-1];
                c0_h[i] <= c0_h[i-1];
                c0_d[i] <= c0_d[i-1];
                c1_v[i] <= c1_v[i-1];
                c1_h[i] <= c1_h[i-1];
            end
        end
    end

    assign c0_rsp_valid = c0_v[LATENCY-1];
    assign c0_rsp_hdr   = c0_h[LATENCY-1];
    assign c0_rsp_data  = c0_d[LATENCY-1];
    assign c1_rsp_valid = c1_v[LATENCY-1];
    assign c1_rsp_hdr   = c1_h[LATENCY-1];

endmodule

// File: tb/tb_cci_mpf_mem_responder.sv
// Scoreboard bench for the MPF memory responder, plus a direct check of the request FIFO's
// almost-full and overflow behaviour with dequeue held off.
module tb_cci_mpf_mem_responder;
    import cci_mpf_mem_responder_pkg::*;

    localparam int MEM_LINES = 64;
    localparam int DEPTH     = 16;
    localparam int LATENCY   = 4;

    logic              clk = 1'b0;
    logic              reset;
    t_if_cci_mpf_c0_Tx c0_tx;
    t_if_cci_mpf_c1_Tx c1_tx;
    logic              c0_tx_almfull;
    logic              c1_tx_almfull;
    logic              c0_rsp_valid;
    t_cci_RspMemHdr    c0_rsp_hdr;
    t_cci_cldata       c0_rsp_data;
    logic              c1_rsp_valid;
    t_cci_RspMemHdr    c1_rsp_hdr;
    logic              err_overflow;
    logic              err_vaddr;

    logic       f_enq = 1'b0;
    logic       f_deq = 1'b0;
    logic [7:0] f_in  = '0;
    logic [7:0] f_out;
    logic       f_not_empty;
    logic       f_almfull;
    logic       f_overflow;

    always #5 clk = ~clk;

    cci_mpf_mem_responder #(
        .MEM_LINES      (MEM_LINES),
        .REQ_FIFO_DEPTH (DEPTH),
        .LATENCY        (LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .c0_tx         (c0_tx),
        .c1_tx         (c1_tx),
        .c0_tx_almfull (c0_tx_almfull),
        .c1_tx_almfull (c1_tx_almfull),
        .c0_rsp_valid  (c0_rsp_valid),
        .c0_rsp_hdr    (c0_rsp_hdr),
        .c0_rsp_data   (c0_rsp_data),
        .c1_rsp_valid  (c1_rsp_valid),
        .c1_rsp_hdr    (c1_rsp_hdr),
        .err_overflow  (err_overflow),
        .err_vaddr     (err_vaddr)
    );

    cci_mpf_mem_responder_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_en    (f_enq),
        .enq_data  (f_in),
        .deq_en    (f_deq),
        .deq_data  (f_out),
        .not_empty (f_not_empty),
        .almfull   (f_almfull),
        .overflow  (f_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        t_cci_RspMemHdr hdr;
        t_cci_cldata    data;
        int             due;
    } exp_c0_t;

    typedef struct {
        t_cci_RspMemHdr hdr;
        int             due;
    } exp_c1_t;

    exp_c0_t     exp_c0 [$];
    exp_c1_t     exp_c1 [$];
    t_cci_cldata model_mem [MEM_LINES];

    // Requests driven now are sampled at the next edge, dequeued the cycle after, and the
    // response becomes visible after LATENCY further edges.
    task automatic set_rd(input t_cci_clAddr addr, input t_cci_mdata md, input logic virt);
        logic [5:0] idx;
        idx = addr[5:0];
        c0_tx.rdValid                = 1'b1;
        c0_tx.hdr.ext.addrIsVirtual  = virt;
        c0_tx.hdr.base.address       = addr;
        c0_tx.hdr.base.mdata         = md;
        exp_c0.push_back('{hdr: '{resp_type: eRSP_RDLINE, mdata: md},
                           data: model_mem[idx], due: cyc + 1 + LATENCY});
    endtask

    task automatic set_c1(input t_cci_clAddr addr, input t_cci_mdata md, input t_cci_cldata data,
                          input logic wr, input logic intr);
        logic [5:0] idx;
        idx = addr[5:0];
        c1_tx.wrValid                = wr;
        c1_tx.intrValid              = intr;
        c1_tx.hdr.ext.addrIsVirtual  = 1'b0;
        c1_tx.hdr.base.address       = addr;
        c1_tx.hdr.base.mdata         = md;
        c1_tx.data                   = data;
        if (wr) model_mem[idx] = data;
        exp_c1.push_back('{hdr: '{resp_type: (wr ? eRSP_WRLINE : eRSP_INTR), mdata: md},
                           due: cyc + 1 + LATENCY});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c0_tx.rdValid   = 1'b0;
        c1_tx.wrValid   = 1'b0;
        c1_tx.intrValid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (c0_rsp_valid) begin
            if (exp_c0.size() == 0) begin
                check("c0_unexpected_rsp", c0_rsp_valid, 1'b0);
            end else begin
                exp_c0_t e;
                e = exp_c0.pop_front();
                check("c0_hdr", c0_rsp_hdr, e.hdr);
                check("c0_data", c0_rsp_data, e.data);
                check("c0_latency", cyc, e.due);
            end
        end
        if (c1_rsp_valid) begin
            if (exp_c1.size() == 0) begin
                check("c1_unexpected_rsp", c1_rsp_valid, 1'b0);
            end else begin
                exp_c1_t e;
                e = exp_c1.pop_front();
                check("c1_hdr", c1_rsp_hdr, e.hdr);
                check("c1_latency", cyc, e.due);
            end
        end
    end

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        while ((exp_c0.size() != 0 || exp_c1.size() != 0) && waited < 64) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check({tag, "_c0_pending"}, exp_c0.size(), 0);
        check({tag, "_c1_pending"}, exp_c1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        t_cci_cldata pat_a5;
        t_cci_cldata pat_07;
        t_cci_cldata pat_9;
        pat_a5 = {64{8'hA5}};
        pat_07 = {16{32'h0707_0707}};
        pat_9  = {8{64'h0123_4567_89AB_CDEF}};

        reset = 1'b1;
        c0_tx = '0;
        c1_tx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c0_valid", c0_rsp_valid, 1'b0);
        check("rst_c1_valid", c1_rsp_valid, 1'b0);
        check("rst_c0_hdr", c0_rsp_hdr, '0);
        check("rst_c0_data", c0_rsp_data, '0);
        check("rst_c1_hdr", c1_rsp_hdr, '0);
        check("rst_almfull", {c0_tx_almfull, c1_tx_almfull}, 2'b00);
        check("rst_errors", {err_overflow, err_vaddr}, 2'b00);
        reset = 1'b0;
        step();

        // Known contents for lines used later.
        set_c1(42'd3, 16'h0003, '0, 1'b1, 1'b0);
        step();
        set_c1(42'd7, 16'h0007, pat_07, 1'b1, 1'b0);
        step();

        // Write then read the same line on the next cycle.
        set_c1(42'd5, 16'h0012, pat_a5, 1'b1, 1'b0);
        step();
        set_rd(42'd5, 16'h0034, 1'b0);
        step();

        // Same-cycle read and write of line 3: read sees old data, later read sees new.
        set_rd(42'd3, 16'h0040, 1'b0);
        set_c1(42'd3, 16'h0041, 512'h1, 1'b1, 1'b0);
        step();
        set_rd(42'd3, 16'h0042, 1'b0);
        step();
        drain("rbw");

        // Back-to-back reads through aliased addresses of line 5; order and data preserved.
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_rd(t_cci_clAddr'(i * MEM_LINES + 5), t_cci_mdata'(16'h0100 + i), 1'b0);
            step();
        end
        check("b2b_c0_almfull", c0_tx_almfull, 1'b0);
        check("b2b_err_overflow", err_overflow, 1'b0);
        check("b2b_err_vaddr", err_vaddr, 1'b0);
        drain("b2b");

        // Virtual address: low bits used as physical index, flag latched.
        set_rd(42'h1_0007, 16'h0077, 1'b1);
        step();
        check("vaddr_flag", err_vaddr, 1'b1);

        // Interrupt acks without touching memory; line 5 must still hold 0xA5.
        set_c1(42'd5, 16'h0055, '0, 1'b0, 1'b1);
        step();
        set_rd(42'd5, 16'h0056, 1'b0);
        step();

        // wrValid together with intrValid behaves as a write.
        set_c1(42'd9, 16'h0060, pat_9, 1'b1, 1'b1);
        step();
        set_rd(42'd9, 16'h0061, 1'b0);
        step();
        drain("intr");
        check("vaddr_sticky", err_vaddr, 1'b1);

        // Reset with three reads in flight: no responses afterwards, flags cleared.
        for (int i = 0; i < 3; i++) begin
            set_rd(42'd7, t_cci_mdata'(16'h0070 + i), 1'b0);
            step();
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_c0.delete();
        exp_c1.delete();
        reset = 1'b0;
        check("midrst_c0_valid", c0_rsp_valid, 1'b0);
        check("midrst_almfull", {c0_tx_almfull, c1_tx_almfull}, 2'b00);
        check("midrst_errors", {err_overflow, err_vaddr}, 2'b00);
        repeat (LATENCY + 4) @(posedge clk);
        #1;
        check("midrst_quiet", {c0_rsp_valid, c1_rsp_valid}, 2'b00);

        // Request FIFO with dequeue held off: almfull at DEPTH - threshold, drop at full.
        for (int k = 1; k <= DEPTH; k++) begin
            f_enq = 1'b1;
            f_in  = 8'(k * 3 + 1);
            @(posedge clk);
            #1;
            check($sformatf("fifo_almfull_fill%0d", k), f_almfull,
                  k >= DEPTH - CCI_ALMOST_FULL_THRESHOLD);
        end
        check("fifo_no_overflow_at_full", f_overflow, 1'b0);
        f_in = 8'hEE;
        @(posedge clk);
        #1;
        f_enq = 1'b0;
        check("fifo_overflow", f_overflow, 1'b1);
        for (int k = 1; k <= DEPTH; k++) begin
            check($sformatf("fifo_data%0d", k), f_out, 8'(k * 3 + 1));
            f_deq = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("fifo_almfull_drain%0d", k), f_almfull,
                  (DEPTH - k) >= DEPTH - CCI_ALMOST_FULL_THRESHOLD);
        end
        f_deq = 1'b0;
        check("fifo_empty", f_not_empty, 1'b0);
        check("fifo_overflow_sticky", f_overflow, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
